// File: rtl/nios0_nios2_gen2_0_cpu_ocimem_arbiter.sv
// rtl/nios0_nios2_gen2_0_cpu_ocimem_arbiter.sv - round-robin arbiter sharing the OCI debug RAM between Avalon and JTAG
module nios0_nios2_gen2_0_cpu_ocimem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter bit FIRST_JTAG = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_av_address,
    input  logic              i_av_read,
    input  logic              i_av_write,
    input  logic [31:0]       i_av_writedata,
    input  logic [3:0]        i_av_byteenable,
    output logic [31:0]       o_av_readdata,
    output logic              o_av_waitrequest,
    input  logic              i_jt_addr_load,
    input  logic              i_jt_write,
    input  logic              i_jt_read,
    input  logic [37:0]       i_jdo,
    output logic [31:0]       o_jt_rdata,
    output logic              o_jt_rd_done,
    output logic              o_jt_busy,
    output logic              o_jt_overflow,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [3:0]        o_ram_be,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_AV_RD, S_JT_RD} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_boot;
    logic              r_last_jt;
    logic              r_slot_full;
    logic              r_slot_wr;
    logic [ADDR_W-1:0] r_slot_addr;
    logic [31:0]       r_slot_data;
    logic [ADDR_W-1:0] r_jtag_addr;
    logic [31:0]       r_jt_rdata;
    logic              r_jt_rd_done;
    logic              r_jt_overflow;

    logic w_av_req;
    logic w_av_wr;
    logic w_can_grant;
    logic w_grant_jt;
    logic w_grant_av;
    logic w_busy;
    logic w_jt_strobe;
    logic w_unused;

    assign w_unused    = ^{i_jdo[37:35], i_jdo[2:0]};
    assign w_av_req    = i_av_read | i_av_write;
    assign w_av_wr     = i_av_write & ~i_av_read;
    // r_boot holds off grants for the first cycle after reset so no write escapes on deassert
    assign w_can_grant = (r_state == S_IDLE) && !r_boot;
    assign w_grant_jt  = w_can_grant && r_slot_full && (!w_av_req || !r_last_jt);
    assign w_grant_av  = w_can_grant && w_av_req && !w_grant_jt;
    assign w_busy      = r_slot_full || (r_state == S_JT_RD);
    assign w_jt_strobe = i_jt_addr_load | i_jt_write | i_jt_read;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_av && !w_av_wr) begin
                    w_next_state = S_AV_RD;
                end else if (w_grant_jt && !r_slot_wr) begin
                    w_next_state = S_JT_RD;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_ram_addr       = '0;
        o_ram_we         = 1'b0;
        o_ram_be         = 4'h0;
        o_ram_wdata      = 32'h0;
        o_av_readdata    = 32'h0;
        o_av_waitrequest = w_av_req;
        if (w_grant_av) begin
            o_ram_addr = i_av_address;
            if (w_av_wr) begin
                o_ram_we         = 1'b1;
                o_ram_be         = i_av_byteenable;
                o_ram_wdata      = i_av_writedata;
                o_av_waitrequest = 1'b0;
            end
        end else if (w_grant_jt) begin
            o_ram_addr = r_slot_addr;
            if (r_slot_wr) begin
                o_ram_we    = 1'b1;
                o_ram_be    = 4'hF;
                o_ram_wdata = r_slot_data;
            end
        end
        if (r_state == S_AV_RD) begin
            o_av_readdata    = i_ram_rdata;
            o_av_waitrequest = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_boot        <= 1'b1;
            r_last_jt     <= !FIRST_JTAG;
            r_slot_full   <= 1'b0;
            r_slot_wr     <= 1'b0;
            r_slot_addr   <= '0;
            r_slot_data   <= 32'h0;
            r_jtag_addr   <= '0;
            r_jt_rdata    <= 32'h0;
            r_jt_rd_done  <= 1'b0;
            r_jt_overflow <= 1'b0;
        end else begin
            r_boot       <= 1'b0;
            r_jt_rd_done <= (r_state == S_JT_RD);
            if (w_grant_jt) begin
                r_last_jt <= 1'b1;
            end else if (w_grant_av) begin
                r_last_jt <= 1'b0;
            end
            if (r_state == S_JT_RD) begin
                r_jt_rdata <= i_ram_rdata;
            end
            if ((w_grant_jt && r_slot_wr) || (r_state == S_JT_RD)) begin
                r_slot_full <= 1'b0;
            end
            if (w_jt_strobe && w_busy) begin
                r_jt_overflow <= 1'b1;
            end else if (i_jt_addr_load) begin
                r_jtag_addr   <= i_jdo[ADDR_W+16:17];
                r_jt_overflow <= 1'b0;
            end else if (i_jt_write || i_jt_read) begin
                r_slot_full <= 1'b1;
                r_slot_wr   <= i_jt_write;
                r_slot_addr <= r_jtag_addr;
                r_slot_data <= i_jdo[34:3];
                r_jtag_addr <= r_jtag_addr + ADDR_W'(1);
            end
        end
    end

    assign o_jt_rdata    = r_jt_rdata;
    assign o_jt_rd_done  = r_jt_rd_done;
    assign o_jt_busy     = w_busy;
    assign o_jt_overflow = r_jt_overflow;

endmodule
